// File: rtl/keypad_entry_pkg.sv
// Shared constants for the keypad entry stage and the countdown chain it feeds.
package keypad_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ENTRY  = 2'd1,
        LOAD   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_START = 4'd11;

    // Codes 0..9 are decimal digits; 10/11 are commands; 12..15 are dead keys.
    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad/counter-chain side signals of the entry stage.
interface keypad_entry_if #(
    parameter int NDIGITS = 4
);
    logic                   key_valid;
    logic [3:0]             key_code;
    logic                   done;
    logic [4*NDIGITS-1:0]   digits;
    logic                   loadn;
    logic                   run_en;
    logic [2:0]             ndig;
    logic                   err;

    modport master (
        output key_valid, key_code, done,
        input  digits, loadn, run_en, ndig, err
    );

    modport slave (
        input  key_valid, key_code, done,
        output digits, loadn, run_en, ndig, err
    );
endinterface

// File: rtl/keypad_entry_key_edge.sv
// Rising-edge detector on the keypad level: one press per held key.
module key_edge (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       press,
    output logic [3:0] code
);
    logic key_q;

    // Previous key level; cleared on reset so a key held through reset counts once.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) key_q <= 1'b0;
        else       key_q <= key_valid;
    end

    // Press is the first cycle of a high level; the code is taken alongside it so
    // the FSM acts on it at the same edge (one clock of latency overall).
    assign press = key_valid & ~key_q;
    assign code  = key_code;
endmodule

// File: rtl/keypad_entry.sv
// Collects BCD MM:SS digits, validates them, loads the down-counter chain and
// holds its enable until the chain reports zero.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int TENS_SEC_MAX = 5
) (
    input logic           clk,
    input logic           clrn,
    keypad_entry_if.slave bus
);
    localparam int W = 4 * NDIGITS;

    state_t         state;
    logic [W-1:0]   digits;
    logic [2:0]     ndig;
    logic           loadn;
    logic           run_en;
    logic           err;
    logic           press;
    logic [3:0]     code;

    key_edge u_key_edge (
        .clk       (clk),
        .clrn      (clrn),
        .key_valid (bus.key_valid),
        .key_code  (bus.key_code),
        .press     (press),
        .code      (code)
    );

    // Entry FSM, digit shift register and registered counter-chain controls.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= EMPTY;
            digits <= '0;
            ndig   <= '0;
            loadn  <= 1'b1;
            run_en <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                EMPTY: begin
                    if (press && is_digit(code)) begin
                        digits <= {digits[W-5:0], code};
                        ndig   <= 3'd1;
                        state  <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (press) begin
                        if (is_digit(code)) begin
                            // A full buffer silently drops extra digits.
                            if (ndig < 3'(NDIGITS)) begin
                                digits <= {digits[W-5:0], code};
                                ndig   <= ndig + 3'd1;
                            end
                        end else if (code == KEY_CLEAR) begin
                            digits <= '0;
                            ndig   <= '0;
                            state  <= EMPTY;
                        end else if (code == KEY_START) begin
                            if (digits[7:4] > 4'(TENS_SEC_MAX)) begin
                                err <= 1'b1;
                            end else begin
                                loadn <= 1'b0;
                                state <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    loadn  <= 1'b1;
                    run_en <= 1'b1;
                    state  <= LOCKED;
                end
                LOCKED: begin
                    // Zero from the chain and CLEAR share the same unlock path.
                    if (bus.done || (press && code == KEY_CLEAR)) begin
                        run_en <= 1'b0;
                        digits <= '0;
                        ndig   <= '0;
                        state  <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.digits = digits;
    assign bus.ndig   = ndig;
    assign bus.loadn  = loadn;
    assign bus.run_en = run_en;
    assign bus.err    = err;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: entry, validation, load/lock and reset cases.
module tb_keypad_entry;
    import keypad_entry_pkg::*;

    logic clk;
    logic clrn;
    int   checks;
    int   errors;
    logic m_err, m_loadn, m_run;

    keypad_entry_if #(.NDIGITS(4)) bus ();

    keypad_entry #(.NDIGITS(4), .TENS_SEC_MAX(5)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_dig, input logic [2:0] e_ndig,
                           input logic e_loadn, input logic e_run, input logic e_err);
        chk({tag, ".digits"}, 32'(bus.digits), 32'(e_dig));
        chk({tag, ".ndig"},   32'(bus.ndig),   32'(e_ndig));
        chk({tag, ".loadn"},  32'(bus.loadn),  32'(e_loadn));
        chk({tag, ".run_en"}, 32'(bus.run_en), 32'(e_run));
        chk({tag, ".err"},    32'(bus.err),    32'(e_err));
    endtask

    // One-cycle key press; returns err/loadn/run_en seen the cycle after the press.
    task automatic press_key(input logic [3:0] c, output logic o_err, output logic o_loadn,
                             output logic o_run);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        o_err   = bus.err;
        o_loadn = bus.loadn;
        o_run   = bus.run_en;
        bus.key_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clrn          = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.done      = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
        clrn = 1'b1;

        // Basic entry and buffer-full behaviour
        press_key(4'd1, m_err, m_loadn, m_run);
        chk_all("first_digit", 16'h0001, 3'd1, 1'b1, 1'b0, 1'b0);
        press_key(4'd3, m_err, m_loadn, m_run);
        press_key(4'd4, m_err, m_loadn, m_run);
        press_key(4'd5, m_err, m_loadn, m_run);
        chk_all("four_digits", 16'h1345, 3'd4, 1'b1, 1'b0, 1'b0);
        press_key(4'd7, m_err, m_loadn, m_run);
        chk_all("fifth_digit", 16'h1345, 3'd4, 1'b1, 1'b0, 1'b0);
        press_key(4'd13, m_err, m_loadn, m_run);
        chk_all("dead_code", 16'h1345, 3'd4, 1'b1, 1'b0, 1'b0);
        press_key(KEY_CLEAR, m_err, m_loadn, m_run);
        chk_all("clear", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

        // START in EMPTY does nothing
        press_key(KEY_START, m_err, m_loadn, m_run);
        chk("start_empty.err", 32'(m_err), 32'd0);
        chk("start_empty.loadn", 32'(m_loadn), 32'd1);
        chk_all("start_empty", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

        // Illegal seconds tens -> one-cycle err, stays in ENTRY
        press_key(4'd1, m_err, m_loadn, m_run);
        press_key(4'd7, m_err, m_loadn, m_run);
        press_key(4'd0, m_err, m_loadn, m_run);
        chk_all("buf_0170", 16'h0170, 3'd3, 1'b1, 1'b0, 1'b0);
        press_key(KEY_START, m_err, m_loadn, m_run);
        chk("reject.err_pulse", 32'(m_err), 32'd1);
        chk("reject.loadn", 32'(m_loadn), 32'd1);
        chk_all("reject_after", 16'h0170, 3'd3, 1'b1, 1'b0, 1'b0);
        press_key(4'd5, m_err, m_loadn, m_run);
        chk_all("still_entry", 16'h1705, 3'd4, 1'b1, 1'b0, 1'b0);
        press_key(KEY_CLEAR, m_err, m_loadn, m_run);

        // Legal START -> one LOAD cycle, then LOCKED
        press_key(4'd1, m_err, m_loadn, m_run);
        press_key(4'd3, m_err, m_loadn, m_run);
        press_key(4'd0, m_err, m_loadn, m_run);
        press_key(KEY_START, m_err, m_loadn, m_run);
        chk("load.loadn_low", 32'(m_loadn), 32'd0);
        chk("load.run_off", 32'(m_run), 32'd0);
        chk("load.err", 32'(m_err), 32'd0);
        chk_all("locked", 16'h0130, 3'd3, 1'b1, 1'b1, 1'b0);
        press_key(4'd9, m_err, m_loadn, m_run);
        press_key(KEY_START, m_err, m_loadn, m_run);
        chk("locked_start.loadn", 32'(m_loadn), 32'd1);
        chk_all("locked_ignore", 16'h0130, 3'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        chk_all("done_unlock", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

        // done outside LOCKED is ignored
        press_key(4'd2, m_err, m_loadn, m_run);
        @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        chk_all("done_in_entry", 16'h0002, 3'd1, 1'b1, 1'b0, 1'b0);
        press_key(KEY_CLEAR, m_err, m_loadn, m_run);

        // Long hold -> exactly one press
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd2;
        repeat (50) @(negedge clk);
        chk_all("long_hold", 16'h0002, 3'd1, 1'b1, 1'b0, 1'b0);
        bus.key_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset while LOCKED
        press_key(4'd1, m_err, m_loadn, m_run);
        press_key(4'd0, m_err, m_loadn, m_run);
        press_key(KEY_START, m_err, m_loadn, m_run);
        chk_all("locked2", 16'h0210, 3'd3, 1'b1, 1'b1, 1'b0);
        #2;
        clrn = 1'b0;
        #1;
        chk_all("async_reset", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

        // Key held across reset release counts once
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd3;
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        chk_all("held_release", 16'h0003, 3'd1, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk_all("held_release_stay", 16'h0003, 3'd1, 1'b1, 1'b0, 1'b0);
        bus.key_valid = 1'b0;
        @(negedge clk);

        // CLEAR and done together while LOCKED
        press_key(KEY_START, m_err, m_loadn, m_run);
        chk("locked3.loadn_low", 32'(m_loadn), 32'd0);
        chk_all("locked3", 16'h0003, 3'd1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = KEY_CLEAR;
        bus.done      = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.done      = 1'b0;
        chk_all("clear_done", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("clear_done_stay", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
        press_key(4'd6, m_err, m_loadn, m_run);
        chk_all("after_unlock", 16'h0006, 3'd1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
